oram_request_frontend: RTL and testbench
========================================

ORAM_REQUEST_FRONTEND -- requirements
Module: oram_request_frontend

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set request-queue entries (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum WAIT cycles before an error response.
REQ-003 clk  in  1  SHALL be the single core clock; all flops rise-edge.
REQ-004 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 req_valid  in  1 / req_ready  out  1  SHALL form the client request handshake.
REQ-006 req_rw  in  1  SHALL select the operation (0 read, 1 write).
REQ-007 req_addr  in  TREE_DEPTH  SHALL carry the block number.
REQ-008 req_wdata  in  BYTE_WIDTH*BYTES_PER_BLOCK  SHALL carry the write data.
REQ-009 resp_valid  out  1 / resp_ready  in  1  SHALL form the client response handshake.
REQ-010 resp_rdata  out  BYTE_WIDTH*BYTES_PER_BLOCK  SHALL carry read data.
REQ-011 resp_rw  out  1  SHALL echo the request's req_rw.
REQ-012 resp_error  out  1  SHALL flag a timed-out request.
REQ-013 oram_block_number  out  TREE_DEPTH, oram_w_value  out  BLOCK_BITS, oram_rw_indicator  out  1, oram_input_ready  out  1  SHALL drive the ORAM core request inputs.
REQ-014 oram_r_value  in  BLOCK_BITS, oram_output_ready  in  1  SHALL receive the ORAM core results.
REQ-015 occupancy  out  $clog2(FIFO_DEPTH+1)  SHALL report queued entries.

Function
REQ-016 Push SHALL occur on an edge with req_valid && req_ready, storing {req_rw, req_addr, req_wdata} at the tail.
REQ-017 req_ready SHALL equal (occupancy < FIFO_DEPTH), from registered count only; a pop in the same cycle SHALL NOT enable a push at full.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one request SHALL be outstanding at the ORAM core.
REQ-020 IDLE: if occupancy>0, SHALL pop the head into issue registers and go to ISSUE; otherwise stay.
REQ-021 ISSUE: oram_input_ready SHALL be 1 for exactly one cycle with oram_* driven from issue registers; next state WAIT, timer cleared.
REQ-022 oram_block_number/oram_w_value/oram_rw_indicator SHALL hold stable from ISSUE until the next pop.
REQ-023 WAIT: oram_output_ready==1 SHALL capture oram_r_value (reads) or zero (writes) into resp_rdata, clear resp_error, go to RESP.
REQ-024 WAIT: when timer reaches TIMEOUT_CYCLES with oram_output_ready==0, SHALL set resp_error=1, resp_rdata=0, go to RESP.
REQ-025 oram_output_ready SHALL be ignored outside WAIT (stale level not acted on).
REQ-026 RESP: resp_valid SHALL be 1 with resp_rdata/resp_rw/resp_error stable until resp_ready; on handshake go to IDLE.
REQ-027 Latency from push edge into empty queue (resp_ready high, core answering immediately) SHALL be 3 edges to resp_valid high.
REQ-028 Pushes SHALL continue to be accepted in any FSM state when not full.
REQ-029 Responses SHALL be returned in request order.

Reset
REQ-030 rst_n low SHALL immediately force: FSM IDLE, queue empty, occupancy 0, req_ready 0 while asserted then 1, resp_valid 0, resp_rdata 0, resp_rw 0, resp_error 0, oram_input_ready 0, all oram_* data outputs 0, timer 0.
REQ-031 Reset mid-operation SHALL discard queued and in-flight requests without a response.

Structure
REQ-032 oramPkg SHALL hold typedef oram_req_t {rw, addr, wdata} and the FSM state enum; widths SHALL derive from TREE_DEPTH, BYTE_WIDTH, BYTES_PER_BLOCK.
REQ-033 Queue SHALL be sub-module oram_req_fifo (push/pop/full/empty/count); FSM, timer and output registers SHALL reside in the top.

Verification
REQ-034 Reset, then read addr 3 with core returning 0xA5 pattern one cycle after input_ready -> one input_ready pulse, resp_valid 3 edges after push, resp_rdata = pattern, resp_error 0.
REQ-035 Push 4 writes back-to-back, core stalled -> occupancy 4, req_ready 0, fifth request not accepted until first pop.
REQ-036 Write addr 5 then read addr 5 -> responses in order, resp_rw 1 then 0, second issue only after first response handshake.
REQ-037 Core never asserts output_ready -> after 255 WAIT cycles resp_valid=1, resp_error=1, resp_rdata=0; next request proceeds normally.
REQ-038 Hold resp_ready 0 for 10 cycles -> resp_* stable, no further input_ready pulses, pushes still accepted.
REQ-039 Deassert rst_n during WAIT with 2 entries queued -> all outputs to reset values immediately, no response after release.

Source files
------------

// File: rtl/oram_request_frontend_pkg.sv
// Shared types and widths for the ORAM request frontend.
package oram_request_frontend_pkg;

    // Block geometry seen by the ORAM core.
    localparam int unsigned TREE_DEPTH      = 8;
    localparam int unsigned BYTE_WIDTH      = 8;
    localparam int unsigned BYTES_PER_BLOCK = 4;
    localparam int unsigned BLOCK_BITS      = BYTE_WIDTH * BYTES_PER_BLOCK;

    // One queued client request.
    typedef struct packed {
        logic                  rw;
        logic [TREE_DEPTH-1:0] addr;
        logic [BLOCK_BITS-1:0] wdata;
    } oram_req_t;

    localparam int unsigned REQ_BITS = $bits(oram_req_t);

    // Sequencer states: one request in flight at the core at any time.
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } oram_state_e;

endpackage

// File: rtl/oram_req_fifo.sv
// Request queue: circular buffer with registered occupancy count.
module oram_req_fifo
    import oram_request_frontend_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  oram_req_t                      i_data,
    input  logic                           i_pop,
    output oram_req_t                      o_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    oram_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: written at the tail on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/oram_request_frontend.sv
// Client-facing frontend: queues requests and serialises them to the ORAM core.
module oram_request_frontend
    import oram_request_frontend_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // client request
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_rw,
    input  logic [TREE_DEPTH-1:0]             req_addr,
    input  logic [BLOCK_BITS-1:0]             req_wdata,
    // client response
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [BLOCK_BITS-1:0]             resp_rdata,
    output logic                              resp_rw,
    output logic                              resp_error,
    // ORAM core
    output logic [TREE_DEPTH-1:0]             oram_block_number,
    output logic [BLOCK_BITS-1:0]             oram_w_value,
    output logic                              oram_rw_indicator,
    output logic                              oram_input_ready,
    input  logic [BLOCK_BITS-1:0]             oram_r_value,
    input  logic                              oram_output_ready,
    // status
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    oram_state_e            r_state;
    oram_state_e            w_state_next;
    logic [TMR_W-1:0]       r_timer;
    logic [TMR_W-1:0]       w_timer_next;
    logic                   r_ready_en;
    oram_req_t              r_issue;
    logic [BLOCK_BITS-1:0]  r_resp_rdata;
    logic                   r_resp_rw;
    logic                   r_resp_error;

    oram_req_t              w_push_data;
    oram_req_t              w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_capture;
    logic                   w_timeout;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign req_ready   = r_ready_en && !w_full;
    assign w_push      = req_valid && req_ready;
    assign w_pop       = (r_state == StIdle) && !w_empty;
    assign w_push_data = '{rw: req_rw, addr: req_addr, wdata: req_wdata};

    oram_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Next-state, timer and capture decisions for the single in-flight request.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_state_next = StWait;
                w_timer_next = '0;
            end
            StWait: begin
                // r_timer counts WAIT cycles already completed; a core answer wins a tie.
                if (oram_output_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = StResp;
                end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = StResp;
                end else begin
                    w_timer_next = r_timer + TMR_W'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State, timer and post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_timer    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_ready_en <= 1'b1;
        end
    end

    // Issue registers: loaded on pop, held stable until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue <= '0;
        end else if (w_pop) begin
            r_issue <= w_head;
        end
    end

    // Response registers: written when WAIT resolves, held through RESP and after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_rdata <= '0;
            r_resp_rw    <= 1'b0;
            r_resp_error <= 1'b0;
        end else if (w_capture) begin
            r_resp_rdata <= r_issue.rw ? '0 : oram_r_value;
            r_resp_rw    <= r_issue.rw;
            r_resp_error <= 1'b0;
        end else if (w_timeout) begin
            r_resp_rdata <= '0;
            r_resp_rw    <= r_issue.rw;
            r_resp_error <= 1'b1;
        end
    end

    assign resp_valid        = (r_state == StResp);
    assign resp_rdata        = r_resp_rdata;
    assign resp_rw           = r_resp_rw;
    assign resp_error        = r_resp_error;
    assign oram_input_ready  = (r_state == StIssue);
    assign oram_block_number = r_issue.addr;
    assign oram_w_value      = r_issue.wdata;
    assign oram_rw_indicator = r_issue.rw;
    assign occupancy         = w_count;

endmodule

// File: tb/tb_oram_request_frontend.sv
// Self-checking bench: transaction-level model plus directed scenarios.
module tb_oram_request_frontend;
    import oram_request_frontend_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 255;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_rw = 1'b0;
    logic [TREE_DEPTH-1:0] req_addr = '0;
    logic [BLOCK_BITS-1:0] req_wdata = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b1;
    logic [BLOCK_BITS-1:0] resp_rdata;
    logic                  resp_rw;
    logic                  resp_error;
    logic [TREE_DEPTH-1:0] oram_block_number;
    logic [BLOCK_BITS-1:0] oram_w_value;
    logic                  oram_rw_indicator;
    logic                  oram_input_ready;
    logic [BLOCK_BITS-1:0] oram_r_value = '0;
    logic                  oram_output_ready = 1'b0;
    logic [2:0]            occupancy;

    oram_request_frontend #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_rw            (req_rw),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_rw           (resp_rw),
        .resp_error        (resp_error),
        .oram_block_number (oram_block_number),
        .oram_w_value      (oram_w_value),
        .oram_rw_indicator (oram_rw_indicator),
        .oram_input_ready  (oram_input_ready),
        .oram_r_value      (oram_r_value),
        .oram_output_ready (oram_output_ready),
        .occupancy         (occupancy)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Queue of waiting requests plus one request in service, tracked by the edge it was taken.
    oram_req_t             mq[$];
    bit                    m_init = 0;
    bit                    m_busy = 0;
    bit                    m_rv = 0;
    int                    m_pop = 0;
    int                    n = 0;
    oram_req_t             m_cur = '0;
    logic [BLOCK_BITS-1:0] m_rdata = '0;
    logic                  m_rw = 1'b0;
    logic                  m_err = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_init = 0; m_busy = 0; m_rv = 0;
            m_cur = '0; m_rdata = '0; m_rw = 1'b0; m_err = 1'b0;
        end else begin
            bit        can_push;
            oram_req_t t;
            can_push = m_init && (mq.size() < DEPTH);
            n++;
            if (m_rv) begin
                if (resp_ready) begin
                    m_rv = 0;
                    m_busy = 0;
                end
            end else if (m_busy) begin
                // core answer is only honoured from the second edge after the pop onward
                if (n >= m_pop + 2) begin
                    if (oram_output_ready) begin
                        m_rv = 1; m_rw = m_cur.rw; m_err = 1'b0;
                        m_rdata = m_cur.rw ? '0 : oram_r_value;
                    end else if (n - m_pop == TMO + 1) begin
                        m_rv = 1; m_rw = m_cur.rw; m_err = 1'b1; m_rdata = '0;
                    end
                end
            end else if (mq.size() > 0) begin
                m_cur = mq.pop_front();
                m_busy = 1;
                m_pop = n;
            end
            if (can_push && req_valid) begin
                t.rw = req_rw; t.addr = req_addr; t.wdata = req_wdata;
                mq.push_back(t);
            end
            m_init = 1;
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("req_ready", 64'(req_ready), 64'(m_init && (mq.size() < DEPTH)));
        chk("input_ready", 64'(oram_input_ready), 64'(m_busy && !m_rv && (n == m_pop)));
        chk("block_number", 64'(oram_block_number), 64'(m_cur.addr));
        chk("w_value", 64'(oram_w_value), 64'(m_cur.wdata));
        chk("rw_indicator", 64'(oram_rw_indicator), 64'(m_cur.rw));
        chk("resp_valid", 64'(resp_valid), 64'(m_rv));
        chk("resp_rdata", 64'(resp_rdata), 64'(m_rdata));
        chk("resp_rw", 64'(resp_rw), 64'(m_rw));
        chk("resp_error", 64'(resp_error), 64'(m_err));
    end

    // ---------------- core responder and response log ----------------
    typedef struct {
        logic                  rw;
        logic                  err;
        logic [BLOCK_BITS-1:0] rdata;
        int                    e_n;
    } log_t;

    log_t                  rlog[$];
    int                    ir_edge[$];
    int                    core_delay = 1;
    logic [BLOCK_BITS-1:0] core_data = 32'hA5A5_A5A5;
    int                    core_cnt = 0;
    int                    ir_pulses = 0;

    initial forever begin
        @(negedge clk);
        oram_output_ready = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                oram_output_ready = 1'b1;
                oram_r_value = core_data;
            end
        end
        if (oram_input_ready) begin
            ir_pulses++;
            ir_edge.push_back(ecnt);
            if (core_delay > 0) core_cnt = core_delay;
        end
        if (resp_valid && resp_ready) begin
            log_t l;
            l.rw = resp_rw; l.err = resp_error; l.rdata = resp_rdata; l.e_n = ecnt;
            rlog.push_back(l);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic rw, input logic [7:0] a, input logic [31:0] d,
                        input int bound, output int ok);
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
        ok = 0;
        for (int k = 0; k < bound; k++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int bound, output int seen_edge);
        int ok;
        ok = 0;
        seen_edge = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1;
                seen_edge = ecnt;
                break;
            end
        end
        chk("resp_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_log(input int target, input int bound);
        for (int k = 0; k < bound && rlog.size() < target; k++) @(negedge clk);
        chk("resp_count", 64'(rlog.size()), 64'(target));
    endtask

    int ok, pe, le, b, p0, acc;

    initial begin
        // reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_input_ready", 64'(oram_input_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // single read, core answers one cycle after input_ready
        p0 = ir_pulses;
        push(1'b0, 8'd3, 32'h0, 10, ok);
        pe = ecnt;
        wait_resp(20, le);
        chk("t1_latency", 64'(le - pe), 64'd3);
        chk("t1_rdata", 64'(resp_rdata), 64'hA5A5_A5A5);
        chk("t1_error", 64'(resp_error), 64'd0);
        chk("t1_rw", 64'(resp_rw), 64'd0);
        repeat (3) @(negedge clk);
        chk("t1_pulses", 64'(ir_pulses - p0), 64'd1);

        // stalled core: fill queue behind a stuck write, then timeout
        core_delay = 0;
        b = rlog.size();
        push(1'b1, 8'd1, 32'h1111_0001, 10, ok);
        pe = ecnt;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 8'(2 + i), 32'h2222_0000 + i, 10, ok);
            chk("t2_push_ok", 64'(ok), 64'd1);
        end
        @(negedge clk);
        chk("t2_occupancy_full", 64'(occupancy), 64'd4);
        chk("t2_ready_full", 64'(req_ready), 64'd0);
        push(1'b0, 8'd6, 32'h0, 20, ok);
        chk("t2_fifth_blocked", 64'(ok), 64'd0);
        core_delay = 1;
        core_data = 32'hA5A5_A5A5;
        push(1'b0, 8'd6, 32'h0, 400, ok);
        acc = ecnt;
        chk("t2_fifth_accepted", 64'(ok), 64'd1);
        chk("t2_fifth_edge", 64'(acc - pe), 64'd260);
        chk("t3_timeout_edge", 64'(rlog[b].e_n - pe), 64'd257);
        chk("t3_timeout_err", 64'(rlog[b].err), 64'd1);
        chk("t3_timeout_rdata", 64'(rlog[b].rdata), 64'd0);
        chk("t3_timeout_rw", 64'(rlog[b].rw), 64'd1);
        wait_log(b + 6, 100);
        for (int i = 1; i < 6; i++) begin
            chk("t3_drain_err", 64'(rlog[b + i].err), 64'd0);
            chk("t3_drain_rw", 64'(rlog[b + i].rw), (i < 5) ? 64'd1 : 64'd0);
        end
        chk("t3_read_rdata", 64'(rlog[b + 5].rdata), 64'hA5A5_A5A5);
        chk("t3_occupancy_empty", 64'(occupancy), 64'd0);

        // write then read of the same block, strictly in order
        core_data = 32'h5A5A_1234;
        b = rlog.size();
        p0 = ir_edge.size();
        push(1'b1, 8'd5, 32'hDEAD_BEEF, 10, ok);
        push(1'b0, 8'd5, 32'h0, 10, ok);
        wait_log(b + 2, 30);
        chk("t4_rw0", 64'(rlog[b].rw), 64'd1);
        chk("t4_rw1", 64'(rlog[b + 1].rw), 64'd0);
        chk("t4_rdata0", 64'(rlog[b].rdata), 64'd0);
        chk("t4_rdata1", 64'(rlog[b + 1].rdata), 64'h5A5A_1234);
        chk("t4_issue_after_hs", 64'(ir_edge[p0 + 1] - rlog[b].e_n), 64'd2);

        // response back-pressure
        @(posedge clk);
        #1 resp_ready = 1'b0;
        b = rlog.size();
        push(1'b0, 8'd7, 32'h0, 10, ok);
        wait_resp(20, le);
        p0 = ir_pulses;
        push(1'b1, 8'd8, 32'h0808_0808, 10, ok);
        chk("t5_push_a", 64'(ok), 64'd1);
        push(1'b0, 8'd9, 32'h0, 10, ok);
        chk("t5_push_b", 64'(ok), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(resp_valid), 64'd1);
            chk("t5_hold_rdata", 64'(resp_rdata), 64'h5A5A_1234);
        end
        chk("t5_no_issue", 64'(ir_pulses - p0), 64'd0);
        chk("t5_occupancy", 64'(occupancy), 64'd2);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_log(b + 3, 40);

        // reset while waiting on the core with two queued
        core_delay = 0;
        p0 = rlog.size();
        push(1'b1, 8'd1, 32'hCAFE_0001, 10, ok);
        push(1'b1, 8'd2, 32'hCAFE_0002, 10, ok);
        push(1'b1, 8'd3, 32'hCAFE_0003, 10, ok);
        @(negedge clk);
        chk("t6_pre_block", 64'(oram_block_number), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_occupancy", 64'(occupancy), 64'd0);
        chk("t6_rst_ready", 64'(req_ready), 64'd0);
        chk("t6_rst_block", 64'(oram_block_number), 64'd0);
        chk("t6_rst_wvalue", 64'(oram_w_value), 64'd0);
        chk("t6_rst_rdata", 64'(resp_rdata), 64'd0);
        chk("t6_rst_valid", 64'(resp_valid), 64'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        core_delay = 1;
        b = ir_pulses;
        repeat (30) @(negedge clk);
        chk("t6_no_resp", 64'(rlog.size() - p0), 64'd0);
        chk("t6_no_issue", 64'(ir_pulses - b), 64'd0);

        // normal traffic after reset
        push(1'b0, 8'd4, 32'h0, 10, ok);
        wait_log(p0 + 1, 20);
        chk("t6_after_rdata", 64'(rlog[p0].rdata), 64'h5A5A_1234);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
